// File: rtl/plab4_net_domain_demux_q_if.sv
// Bundle of the domain-demux links: one tagged input link, N per-domain output links
// and the per-domain status outputs.
interface plab4_net_domain_demux_q_if #(
    parameter int p_msg_cnbits  = 32,
    parameter int p_msg_dnbits  = 32,
    parameter int p_num_domains = 2,
    parameter int p_depth       = 2,
    parameter int c_dom_nbits   = $clog2(p_num_domains),
    parameter int c_cnt_nbits   = $clog2(p_depth) + 1
);
    // Handshake: a message moves on a link in every cycle where its val and rdy are both
    // high at the rising edge; val never waits on rdy, and a message stays stable while val
    // is high and rdy is low.
    logic                                    in_val;
    logic                                    in_rdy;
    logic [c_dom_nbits-1:0]                  in_domain;
    logic [p_msg_cnbits-1:0]                 in_msg_control;
    logic [p_msg_dnbits-1:0]                 in_msg_data;
    logic [p_num_domains-1:0]                out_val;
    logic [p_num_domains-1:0]                out_rdy;
    logic [p_num_domains*p_msg_cnbits-1:0]   out_msg_control;
    logic [p_num_domains*p_msg_dnbits-1:0]   out_msg_data;
    logic [p_num_domains*c_cnt_nbits-1:0]    num_free;
    logic                                    err_bad_domain;

    modport master (
        output in_val, in_domain, in_msg_control, in_msg_data, out_rdy,
        input  in_rdy, out_val, out_msg_control, out_msg_data, num_free, err_bad_domain
    );

    modport slave (
        input  in_val, in_domain, in_msg_control, in_msg_data, out_rdy,
        output in_rdy, out_val, out_msg_control, out_msg_data, num_free, err_bad_domain
    );
endinterface

// File: rtl/plab4_net_domain_demux_q.sv
// Steers a domain-tagged link into per-domain FIFOs with independent output links.
// Optional same-cycle bypass of an empty FIFO: define PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN.
module plab4_net_domain_demux_q #(
    parameter int p_msg_cnbits  = 32,
    parameter int p_msg_dnbits  = 32,
    parameter int p_num_domains = 2,
    parameter int p_depth       = 2,
    parameter int c_dom_nbits   = $clog2(p_num_domains),
    parameter int c_cnt_nbits   = $clog2(p_depth) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    plab4_net_domain_demux_q_if.slave  bus
);
    localparam int c_ptr_nbits = $clog2(p_depth);

    typedef logic [c_ptr_nbits-1:0] ptr_t;
    typedef logic [c_cnt_nbits-1:0] cnt_t;

    localparam cnt_t c_depth = cnt_t'(p_depth);

    logic [p_msg_cnbits-1:0] ctrl_mem [p_num_domains][p_depth];
    logic [p_msg_dnbits-1:0] data_mem [p_num_domains][p_depth];

    ptr_t head_q  [p_num_domains];
    ptr_t tail_q  [p_num_domains];
    cnt_t count_q [p_num_domains];
    logic err_q;

    logic [p_num_domains-1:0] full;
    logic [p_num_domains-1:0] empty;
    logic [p_num_domains-1:0] sel;
    logic [p_num_domains-1:0] enq;
    logic [p_num_domains-1:0] wr;
    logic [p_num_domains-1:0] deq;
    logic                     rdy;
`ifdef PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN
    logic [p_num_domains-1:0] byp;
`endif

    // An out-of-range tag selects no domain, so it is always ready and never enqueues.
    always_comb begin
        full  = '0;
        empty = '0;
        sel   = '0;
        for (int d = 0; d < p_num_domains; d++) begin
            full[d]  = (count_q[d] == c_depth);
            empty[d] = (count_q[d] == '0);
            sel[d]   = (bus.in_domain == c_dom_nbits'(d));
        end
    end

    always_comb begin
        rdy = 1'b1;
        for (int d = 0; d < p_num_domains; d++) begin
            if (sel[d]) rdy = !full[d];
        end
    end

    assign bus.in_rdy         = rdy;
    assign bus.err_bad_domain = err_q;

    always_comb begin
        bus.out_val         = '0;
        bus.out_msg_control = '0;
        bus.out_msg_data    = '0;
        bus.num_free        = '0;
        enq                 = '0;
        wr                  = '0;
        deq                 = '0;
`ifdef PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN
        byp                 = '0;
`endif
        for (int d = 0; d < p_num_domains; d++) begin
            enq[d] = bus.in_val && sel[d] && !full[d];
            deq[d] = !empty[d] && bus.out_rdy[d];
`ifdef PLAB4_NET_DOMAIN_DEMUX_BYPASS_EN
            // An empty FIFO forwards the input directly; it is stored only if not taken.
            byp[d]         = empty[d] && bus.in_val && sel[d];
            bus.out_val[d] = !empty[d] || byp[d];
            wr[d]          = enq[d] && !(byp[d] && bus.out_rdy[d]);
            if (byp[d]) begin
                bus.out_msg_control[d*p_msg_cnbits +: p_msg_cnbits] = bus.in_msg_control;
                bus.out_msg_data[d*p_msg_dnbits +: p_msg_dnbits]    = bus.in_msg_data;
            end else begin
                bus.out_msg_control[d*p_msg_cnbits +: p_msg_cnbits] = ctrl_mem[d][head_q[d]];
                bus.out_msg_data[d*p_msg_dnbits +: p_msg_dnbits]    = data_mem[d][head_q[d]];
            end
`else
            bus.out_val[d] = !empty[d];
            wr[d]          = enq[d];
            bus.out_msg_control[d*p_msg_cnbits +: p_msg_cnbits] = ctrl_mem[d][head_q[d]];
            bus.out_msg_data[d*p_msg_dnbits +: p_msg_dnbits]    = data_mem[d][head_q[d]];
`endif
            bus.num_free[d*c_cnt_nbits +: c_cnt_nbits] = c_depth - count_q[d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < p_num_domains; d++) begin
                head_q[d]  <= '0;
                tail_q[d]  <= '0;
                count_q[d] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int d = 0; d < p_num_domains; d++) begin
                if (wr[d])  tail_q[d] <= tail_q[d] + ptr_t'(1);
                if (deq[d]) head_q[d] <= head_q[d] + ptr_t'(1);
                case ({wr[d], deq[d]})
                    2'b10:   count_q[d] <= count_q[d] + cnt_t'(1);
                    2'b01:   count_q[d] <= count_q[d] - cnt_t'(1);
                    default: count_q[d] <= count_q[d];
                endcase
            end
            if (bus.in_val && (sel == '0)) err_q <= 1'b1;
        end
    end

    // Payload storage carries no reset; validity lives entirely in the counts.
    always_ff @(posedge clk) begin
        for (int d = 0; d < p_num_domains; d++) begin
            if (wr[d]) begin
                ctrl_mem[d][tail_q[d]] <= bus.in_msg_control;
                data_mem[d][tail_q[d]] <= bus.in_msg_data;
            end
        end
    end
endmodule
